// File: rtl/ps2_move_decoder.sv
// Receive-only PS/2 keyboard front end: deserialises device-to-host frames,
// tracks E0/F0 prefixes and holds one level per arrow (and optional WASD) key.
module ps2_move_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter bit WASD_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_s, dat_s;
  logic          fclk, fclk_d;
  logic [FW-1:0] fcnt;
  logic          strobe, bit_in;

  state_t        state;
  logic [2:0]    bcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          ext, brk;

  // Filtered clock only follows the synchronised line after FILTER_LEN
  // consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s  <= 2'b11;
      dat_s  <= 2'b11;
      fclk   <= 1'b1;
      fclk_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      dat_s  <= {dat_s[0], ps2_data};
      fclk_d <= fclk;
      if (clk_s[1] == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fclk <= clk_s[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign strobe = fclk_d & ~fclk;
  assign bit_in = dat_s[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bcnt       <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      move_up    <= 1'b0;
      move_down  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      key_code   <= 8'h00;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state <= DATA;
              bcnt  <= '0;
            end else begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
          DATA: begin
            shreg <= {bit_in, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= bit_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (bit_in && (^{shreg, par})) begin
              key_code  <= shreg;
              key_valid <= 1'b1;
              case (shreg)
                8'hE0: ext <= 1'b1;
                8'hF0: brk <= 1'b1;
                default: begin
                  ext <= 1'b0;
                  brk <= 1'b0;
                  if (ext) begin
                    case (shreg)
                      8'h75:   move_up    <= ~brk;
                      8'h72:   move_down  <= ~brk;
                      8'h6B:   move_left  <= ~brk;
                      8'h74:   move_right <= ~brk;
                      default: ;
                    endcase
                  end else if (WASD_EN) begin
                    case (shreg)
                      8'h1D:   move_up    <= ~brk;
                      8'h1B:   move_down  <= ~brk;
                      8'h1C:   move_left  <= ~brk;
                      8'h23:   move_right <= ~brk;
                      default: ;
                    endcase
                  end
                end
              endcase
            end else begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // A stalled keyboard must not leave a half-built byte or stale prefix.
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          ext       <= 1'b0;
          brk       <= 1'b0;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end
endmodule
